sb_tx_msg_arbiter: RTL

Sequences sideband messages from two requesters, the PHY (LTSM) and the D2D adapter (RDI), into the shared 64-bit sideband TX FIFO. Every message is written atomically as two consecutive words: header, then payload or 64'b0 for no-data messages. This is the two-word layout the downstream credit notifier depends on. The block tracks FIFO occupancy locally, admits a message only when both words fit, and round-robins between requesters. Adapter messages are admitted only while the inband-presence flag is high.

---
 rtl/sb_tx_msg_arbiter_pkg.sv | 21 ++
 rtl/sb_tx_msg_arbiter_if.sv | 36 +++
 rtl/sb_tx_msg_arbiter_rr_arb2.sv | 38 +++
 rtl/sb_tx_msg_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/sb_tx_msg_arbiter_pkg.sv
// Shared types for the sideband TX message arbiter: FSM states, requester ids
// and the 64-bit word type.
package sb_tx_arb_pkg;

  typedef logic [63:0] sb_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_HDR  = 2'd1,
    WR_DATA = 2'd2
  } state_e;

  localparam logic REQ_PHY = 1'b0;
  localparam logic REQ_ADP = 1'b1;

  // Second word of a message: the payload, or all zeros for no-data messages.
  function automatic sb_word_t data_word(input logic has_data, input sb_word_t data);
    return has_data ? data : '0;
  endfunction

endpackage

// File: rtl/sb_tx_msg_arbiter_if.sv
// Requester, FIFO and status signals of the sideband TX message arbiter.
interface sb_tx_msg_arbiter_if;
  import sb_tx_arb_pkg::*;

  logic     phy_req;
  sb_word_t phy_hdr;
  sb_word_t phy_data;
  logic     phy_has_data;
  logic     phy_gnt;
  logic     adp_req;
  sb_word_t adp_hdr;
  sb_word_t adp_data;
  logic     adp_has_data;
  logic     adp_gnt;
  logic     pl_inband_pres;
  logic     fifo_rd_en;
  logic     fifo_wr_en;
  sb_word_t fifo_wr_data;
  logic     busy;
  logic     underflow_err;

  modport master (
    output phy_req, phy_hdr, phy_data, phy_has_data,
    output adp_req, adp_hdr, adp_data, adp_has_data,
    output pl_inband_pres, fifo_rd_en,
    input  phy_gnt, adp_gnt, fifo_wr_en, fifo_wr_data, busy, underflow_err
  );

  modport slave (
    input  phy_req, phy_hdr, phy_data, phy_has_data,
    input  adp_req, adp_hdr, adp_data, adp_has_data,
    input  pl_inband_pres, fifo_rd_en,
    output phy_gnt, adp_gnt, fifo_wr_en, fifo_wr_data, busy, underflow_err
  );

endinterface

// File: rtl/sb_tx_msg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is PHY, bit 1 is the adapter.
module sb_rr_arb2
  import sb_tx_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       last_winner
);

  logic last_winner_q;
  logic last_winner_d;

  always_comb begin
    gnt           = req;
    last_winner_d = last_winner_q;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = (last_winner_q == REQ_ADP) ? 2'b01 : 2'b10;
    end
    if (adv && (|req)) begin
      last_winner_d = gnt[1] ? REQ_ADP : REQ_PHY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_q <= REQ_ADP;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

  assign last_winner = last_winner_q;

endmodule

// File: rtl/sb_tx_msg_arbiter.sv
// Writes PHY / adapter sideband messages into the TX FIFO as atomic
// header + payload word pairs, admitting a message only when both words fit.
module sb_tx_msg_arbiter
  import sb_tx_arb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_phy_req,
  input  sb_word_t i_phy_hdr,
  input  sb_word_t i_phy_data,
  input  logic     i_phy_has_data,
  output logic     o_phy_gnt,
  input  logic     i_adp_req,
  input  sb_word_t i_adp_hdr,
  input  sb_word_t i_adp_data,
  input  logic     i_adp_has_data,
  output logic     o_adp_gnt,
  input  logic     i_pl_inband_pres,
  input  logic     i_fifo_rd_en,
  output logic     o_fifo_wr_en,
  output sb_word_t o_fifo_wr_data,
  output logic     o_busy,
  output logic     o_underflow_err
);

  state_e   state_q, state_d;
  logic [CW-1:0] occ_q, occ_d;
  logic     uf_q, uf_d;
  sb_word_t hdr_q, hdr_d;
  sb_word_t data_q, data_d;
  logic     phy_has_q, phy_has_d;
  logic     adp_has_q, adp_has_d;

  logic       space_ok;
  logic       can_issue;
  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       grant;
  logic       last_winner;
  logic       rd_ok;

  // Registered occupancy only: a pop in the grant cycle is credited next cycle.
  assign space_ok  = (occ_q <= CW'(DEPTH - 2));
  assign can_issue = (state_q == IDLE) && space_ok;
  assign arb_req   = {i_adp_req & i_pl_inband_pres, i_phy_req} & {2{can_issue}};
  assign grant     = |arb_gnt;

  sb_rr_arb2 u_rr_arb2 (
    .clk         (i_clk),
    .rst         (i_rst),
    .req         (arb_req),
    .adv         (can_issue),
    .gnt         (arb_gnt),
    .last_winner (last_winner)
  );

  assign o_phy_gnt = arb_gnt[0];
  assign o_adp_gnt = arb_gnt[1];
  assign o_busy    = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    hdr_d          = hdr_q;
    data_d         = data_q;
    phy_has_d      = phy_has_q;
    adp_has_d      = adp_has_q;
    o_fifo_wr_en   = 1'b0;
    o_fifo_wr_data = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = WR_HDR;
          hdr_d     = arb_gnt[1] ? i_adp_hdr  : i_phy_hdr;
          data_d    = arb_gnt[1] ? i_adp_data : i_phy_data;
          phy_has_d = i_phy_has_data;
          adp_has_d = i_adp_has_data;
        end
      end
      WR_HDR: begin
        o_fifo_wr_en   = 1'b1;
        o_fifo_wr_data = hdr_q;
        state_d        = WR_DATA;
      end
      WR_DATA: begin
        // The arbiter's last winner is the owner of the message in flight.
        o_fifo_wr_en   = 1'b1;
        o_fifo_wr_data = data_word((last_winner == REQ_ADP) ? adp_has_q : phy_has_q, data_q);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ok = i_fifo_rd_en && (occ_q != '0);
    occ_d = occ_q + CW'(o_fifo_wr_en) - CW'(rd_ok);
    uf_d  = uf_q | (i_fifo_rd_en && (occ_q == '0));
  end

  assign o_underflow_err = uf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      uf_q    <= uf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    hdr_q     <= hdr_d;
    data_q    <= data_d;
    phy_has_q <= phy_has_d;
    adp_has_q <= adp_has_d;
  end

endmodule
